// File: rtl/sync_fifo_pkg.sv
// Shared types for the sync_fifo_ext family: read-mode selection.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo_ext: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8,
  localparam int ADDR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses never exceed DATA_DEPTH-1, so non-power-of-2 depths index safely.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, STD/FWFT read modes, programmable
// almost-full/almost-empty thresholds and registered overflow/underflow pulses.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         DATA_DEPTH = 8,
  parameter fifo_mode_e READ_MODE  = FIFO_STD,
  parameter int         AF_LEVEL   = DATA_DEPTH - 2,
  parameter int         AE_LEVEL   = 2,
  localparam int        PTR_W      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int        CNT_W      = $clog2(DATA_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      fifo_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_DEPTH);

  if (DATA_DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_ext: DATA_DEPTH must be at least 2");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_chk_order
    $error("sync_fifo_ext: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DATA_DEPTH) begin : g_chk_af
    $error("sync_fifo_ext: AF_LEVEL must not exceed DATA_DEPTH");
  end
  if (AE_LEVEL < 0) begin : g_chk_ae
    $error("sync_fifo_ext: AE_LEVEL must be non-negative");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags decode the registered count only, so they move one cycle after the edge.
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CNT_FULL);
  assign almost_empty = (int'(cnt_q) <= AE_LEVEL);
  assign almost_full  = (int'(cnt_q) >= AF_LEVEL);
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read frees a slot in the same edge, so a full FIFO can still take a write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = wr_en && !wr_acc;
    unf_d    = rd_en && !rd_acc;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (READ_MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // The RAM read is asynchronous, so a full-and-write edge still captures the old head.
    always_comb begin
      dout_d = dout_q;
      if (rd_acc) begin
        dout_d = rd_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    assign data_out = rd_data;
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench: DUT A is depth 8 / STD, DUT B is depth 6 / FWFT.
module tb_sync_fifo_ext;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       a_rst_n, a_wr, a_rd;
  logic [7:0] a_din, a_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic [3:0] a_cnt;

  logic       b_rst_n, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [3:0] b_cnt;

  sync_fifo_ext #(
    .DATA_WIDTH (8), .DATA_DEPTH (8), .READ_MODE (FIFO_STD),
    .AF_LEVEL (6), .AE_LEVEL (2)
  ) u_dut_a (
    .clk (clk), .rst_n (a_rst_n), .wr_en (a_wr), .data_in (a_din),
    .rd_en (a_rd), .data_out (a_dout), .empty (a_empty), .full (a_full),
    .almost_empty (a_ae), .almost_full (a_af), .fifo_cnt (a_cnt),
    .overflow (a_ovf), .underflow (a_unf)
  );

  sync_fifo_ext #(
    .DATA_WIDTH (8), .DATA_DEPTH (6), .READ_MODE (FIFO_FWFT),
    .AF_LEVEL (4), .AE_LEVEL (2)
  ) u_dut_b (
    .clk (clk), .rst_n (b_rst_n), .wr_en (b_wr), .data_in (b_din),
    .rd_en (b_rd), .data_out (b_dout), .empty (b_empty), .full (b_full),
    .almost_empty (b_ae), .almost_full (b_af), .fifo_cnt (b_cnt),
    .overflow (b_ovf), .underflow (b_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic wr, input logic [7:0] din, input logic rd);
    a_wr  = wr;
    a_din = din;
    a_rd  = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_set(1'b0, 8'h00, 1'b0);
    b_wr = 1'b0; b_din = 8'h00; b_rd = 1'b0;
    tick();
    tick();
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Reset state
    check("a_rst_empty", 32'(a_empty), 1);
    check("a_rst_ae",    32'(a_ae),    1);
    check("a_rst_full",  32'(a_full),  0);
    check("a_rst_af",    32'(a_af),    0);
    check("a_rst_cnt",   32'(a_cnt),   0);
    check("a_rst_ovf",   32'(a_ovf),   0);
    check("a_rst_unf",   32'(a_unf),   0);
    check("a_rst_dout",  32'(a_dout),  0);
    check("b_rst_empty", 32'(b_empty), 1);
    check("b_rst_flags", 32'({b_full, b_af, b_ae, b_ovf, b_unf}), 32'b00100);

    // 1: fill A0..A7, watch thresholds, then overflow
    for (int i = 0; i < 8; i++) begin
      a_set(1'b1, 8'hA0 + 8'(i), 1'b0);
      tick();
      check($sformatf("t1_cnt_%0d", i + 1), 32'(a_cnt), i + 1);
      check($sformatf("t1_ae_%0d", i + 1),  32'(a_ae),  (i + 1 <= 2) ? 1 : 0);
      check($sformatf("t1_af_%0d", i + 1),  32'(a_af),  (i + 1 >= 6) ? 1 : 0);
    end
    check("t1_full", 32'(a_full), 1);
    a_set(1'b1, 8'hEE, 1'b0);
    tick();
    check("t1_ovf",     32'(a_ovf), 1);
    check("t1_ovf_cnt", 32'(a_cnt), 8);
    a_set(1'b0, 8'h00, 1'b0);
    tick();
    check("t1_ovf_clr", 32'(a_ovf), 0);

    // 2: drain with one-cycle STD latency, then underflow holds data
    for (int i = 0; i < 8; i++) begin
      a_set(1'b0, 8'h00, 1'b1);
      tick();
      check($sformatf("t2_dout_%0d", i), 32'(a_dout), 32'h0A0 + i);
    end
    check("t2_empty", 32'(a_empty), 1);
    tick();
    check("t2_unf",      32'(a_unf),  1);
    check("t2_unf_hold", 32'(a_dout), 32'hA7);
    a_set(1'b0, 8'h00, 1'b0);
    tick();
    check("t2_unf_clr", 32'(a_unf), 0);

    // 3: refill B0..B7, then write+read while full
    for (int i = 0; i < 8; i++) begin
      a_set(1'b1, 8'hB0 + 8'(i), 1'b0);
      tick();
    end
    check("t3_full", 32'(a_full), 1);
    for (int i = 0; i < 3; i++) begin
      a_set(1'b1, 8'h55, 1'b1);
      tick();
      check($sformatf("t3_rw_dout_%0d", i), 32'(a_dout), 32'h0B0 + i);
      check($sformatf("t3_rw_cnt_%0d", i),  32'(a_cnt),  8);
      check($sformatf("t3_rw_ovf_%0d", i),  32'(a_ovf),  0);
    end
    for (int i = 0; i < 8; i++) begin
      a_set(1'b0, 8'h00, 1'b1);
      tick();
      check($sformatf("t3_drain_%0d", i), 32'(a_dout), (i < 5) ? (32'h0B3 + i) : 32'h55);
    end
    check("t3_empty", 32'(a_empty), 1);

    // 5: simultaneous write/read on empty
    a_set(1'b1, 8'h77, 1'b1);
    tick();
    check("t5_unf",   32'(a_unf),   1);
    check("t5_cnt",   32'(a_cnt),   1);
    check("t5_empty", 32'(a_empty), 0);
    check("t5_dout",  32'(a_dout),  32'h55);
    a_set(1'b0, 8'h00, 1'b1);
    tick();
    check("t5_read", 32'(a_dout), 32'h77);
    a_set(1'b0, 8'h00, 1'b0);

    // 6: async reset mid-cycle with 5 words stored
    for (int i = 0; i < 5; i++) begin
      a_set(1'b1, 8'hC0 + 8'(i), 1'b0);
      tick();
    end
    a_set(1'b0, 8'h00, 1'b0);
    check("t6_cnt_pre", 32'(a_cnt), 5);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("t6_cnt",   32'(a_cnt),   0);
    check("t6_empty", 32'(a_empty), 1);
    check("t6_flags", 32'({a_full, a_af, a_ae, a_ovf, a_unf}), 32'b00100);
    check("t6_dout",  32'(a_dout),  0);
    tick();
    a_rst_n = 1'b1;
    a_set(1'b1, 8'hD1, 1'b0);
    tick();
    a_set(1'b0, 8'h00, 1'b1);
    tick();
    check("t6_new_data", 32'(a_dout),  32'hD1);
    check("t6_new_empty", 32'(a_empty), 1);
    a_set(1'b0, 8'h00, 1'b0);

    // 4: FWFT stream across pointer wrap on depth-6 FIFO
    b_wr = 1'b1; b_din = 8'h11; b_rd = 1'b0;
    tick();
    check("t4_first_dout",  32'(b_dout),  32'h11);
    check("t4_first_empty", 32'(b_empty), 0);
    for (int i = 0; i < 20; i++) begin
      b_wr = 1'b1; b_din = 8'h20 + 8'(i); b_rd = 1'b1;
      tick();
      check($sformatf("t4_dout_%0d", i), 32'(b_dout), 32'h20 + i);
      check($sformatf("t4_cnt_%0d", i),  32'(b_cnt),  1);
    end
    b_wr = 1'b0; b_din = 8'h00; b_rd = 1'b1;
    tick();
    check("t4_empty", 32'(b_empty), 1);
    b_rd = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised single-clock FIFO, next generation of the team's counter-based sync_fifo. Adds:
- arbitrary (non-power-of-2) depth
- selectable standard or first-word-fall-through read mode
- programmable almost_full / almost_empty thresholds
- overflow / underflow error pulses
- simultaneous read+write when full

It is the generic buffering element for datapath blocks that need flow-control headroom.

Parameters:
DATA_WIDTH, 8, data bit width (>=1)
DATA_DEPTH, 8, number of entries (>=2, any integer)
READ_MODE, FIFO_STD, fifo_mode_e: FIFO_STD (registered read) or FIFO_FWFT (fall-through)
AF_LEVEL, DATA_DEPTH-2, almost_full asserts when fifo_cnt >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when fifo_cnt <= AE_LEVEL

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request
data_out  out  DATA_WIDTH  read data
empty  out  1  fifo_cnt == 0
full  out  1  fifo_cnt == DATA_DEPTH
almost_empty  out  1  fifo_cnt <= AE_LEVEL
almost_full  out  1  fifo_cnt >= AF_LEVEL
fifo_cnt  out  $clog2(DATA_DEPTH)+1  current occupancy
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n; clock port is clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, fifo_cnt = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (AF_LEVEL > 0)
  - overflow = underflow = 0
  - data_out = 0 in FIFO_STD mode
  - Memory contents are not reset.
- Reset mid-operation clears all of the above immediately. Stored data is discarded.
- Accept rules, evaluated on registered state at the clock edge:
  - rd_acc = rd_en && !empty
  - wr_acc = wr_en && (!full || rd_acc). Full with simultaneous read: both accepted, fifo_cnt unchanged.
  - Empty with simultaneous wr/rd: only the write is accepted. The read is rejected and underflow pulses.
- fifo_cnt next value:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither
  - Never exceeds DATA_DEPTH and never goes below 0.
- Pointers: increment on their accept and wrap from DATA_DEPTH-1 to 0. No power-of-2 assumption.
- Flags are a combinational decode of registered fifo_cnt. They change in the cycle after the causing edge.
- overflow is registered: 1 in the cycle after an edge with wr_en && !wr_acc. underflow likewise for rd_en && !rd_acc. Each pulses every cycle the condition recurs.
- FIFO_STD mode:
  - data_out is registered and loads mem[rd_ptr] on rd_acc, giving 1-cycle read latency.
  - It holds its value otherwise, including on a rejected read.
  - Read-before-write: when full with simultaneous rd/wr, the old word is read.
- FIFO_FWFT mode:
  - data_out = mem[rd_ptr] combinationally. The head word is valid whenever !empty; rd_en acknowledges and pops it.
  - data_out is unspecified while empty; benches must not check it.
  - A word written to an empty FIFO appears on data_out in the cycle after the write edge, when empty deasserts.
- Elaboration check ($error):
  - DATA_DEPTH < 2
  - AE_LEVEL >= AF_LEVEL
  - AF_LEVEL > DATA_DEPTH
  - AE_LEVEL < 0

Decomposition:
- Package sync_fifo_pkg: typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}.
- Sub-module fifo_ram:
  - parameters DATA_WIDTH, DATA_DEPTH
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - no reset
- sync_fifo_ext holds pointers, counter, flags, error pulses and the STD output register.

Test Plan:
1. DEPTH=8, AF=6, AE=2, STD. Write 8 words A0..A7 without reads:
   - almost_empty drops after the 3rd write; almost_full rises after the 6th.
   - full=1 and fifo_cnt=8 after the 8th.
   - A 9th write gives overflow=1 for one cycle; fifo_cnt stays 8.
2. From full, STD mode, read 8 times:
   - data_out = A0..A7, each one cycle after its rd_en edge.
   - empty=1 after the 8th read.
   - A 9th read gives underflow=1; data_out holds A7.
3. Full FIFO, wr_en=rd_en=1 with data 0x55 for 3 cycles:
   - fifo_cnt stays 8, no overflow.
   - Reads return the oldest 3 words.
   - 0x55 is later read at the tail in order.
4. DEPTH=6, FWFT. Write 0x11, then stream 20 write+read pairs with incrementing data:
   - data_out shows 0x11 in the cycle after the first write.
   - Order is preserved across pointer wrap at 5->0; fifo_cnt stays 1.
5. Empty FIFO, wr_en=rd_en=1 on the same edge:
   - write accepted, underflow=1, fifo_cnt=1, empty=0 next cycle.
6. Fill with 5 words, deassert rst_n asynchronously mid-cycle:
   - empty=1, fifo_cnt=0, flags and data_out at reset values immediately, without waiting for a clock edge.
   - After release, the next write/read returns the new data only.
